// File: rtl/pipe_tap_pkg.sv
// Shared encodings for the tap-chain checker: FSM states, vote codes and mode values.
package pipe_tap_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    HUNT   = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    PIPE = 2'd1,
    COLL = 2'd2,
    BAD  = 2'd3
  } vote_t;

  localparam logic MODE_PIPE = 1'b0;
  localparam logic MODE_COLL = 1'b1;

  localparam int         VOTE_CNT_W    = 4;
  localparam logic [1:0] PRIME_SAMPLES = 2'd2;

  function automatic logic vote_is_real(input vote_t v);
    return (v == PIPE) || (v == COLL);
  endfunction

  function automatic logic vote_to_mode(input vote_t v);
    return (v == COLL) ? MODE_COLL : MODE_PIPE;
  endfunction

endpackage

// File: rtl/pipe_tap_checker_if.sv
// Tap inputs, verdict outputs and debug taps of pipe_tap_checker.
// Optional log outputs exist only when PIPE_TAP_CHECKER_LOG_EN is defined.
interface pipe_tap_checker_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  import pipe_tap_pkg::*;

  // No valid/ready pair: en qualifies each sample and the checker never stalls the source.
  logic             en;
  logic             clr;
  logic [W-1:0]     b;
  logic [W-1:0]     c;
  logic [W-1:0]     d;

  logic             locked;
  logic             mode;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic             fault;

  state_t                  state_dbg;
  logic [VOTE_CNT_W-1:0]   vote_cnt_dbg;

`ifdef PIPE_TAP_CHECKER_LOG_EN
  logic [3*W-1:0]   first_bad;
  logic [15:0]      first_stamp;
  logic             log_valid;

  modport master (
    output en, clr, b, c, d,
    input  locked, mode, err, err_cnt, fault, state_dbg, vote_cnt_dbg,
    input  first_bad, first_stamp, log_valid
  );

  modport slave (
    input  en, clr, b, c, d,
    output locked, mode, err, err_cnt, fault, state_dbg, vote_cnt_dbg,
    output first_bad, first_stamp, log_valid
  );
`else
  modport master (
    output en, clr, b, c, d,
    input  locked, mode, err, err_cnt, fault, state_dbg, vote_cnt_dbg
  );

  modport slave (
    input  en, clr, b, c, d,
    output locked, mode, err, err_cnt, fault, state_dbg, vote_cnt_dbg
  );
`endif

endinterface

// File: rtl/pipe_tap_vote.sv
// Combinational classifier: compares the current taps with the previous sample's b/c
// and reports whether the chain looks like a shift pipeline, a collapsed chain, neither or both.
module pipe_tap_vote
  import pipe_tap_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] prev_b,
  input  logic [W-1:0] prev_c,
  output logic         p_ok,
  output logic         k_ok,
  output vote_t        vote
);

  always_comb begin
    p_ok = (c == prev_b) && (d == prev_c);
    k_ok = (b == c) && (c == d);
    vote = NONE;
    unique case ({p_ok, k_ok})
      2'b10:   vote = PIPE;
      2'b01:   vote = COLL;
      2'b11:   vote = NONE;   // constant data fits both models
      default: vote = BAD;
    endcase
  end

endmodule

// File: rtl/pipe_tap_checker.sv
// Classifies the b/c/d tap chain as pipeline or collapsed, locks the mode and flags violations.
// Define PIPE_TAP_CHECKER_LOG_EN to capture the taps and a stamp of the first locked mismatch.
module pipe_tap_checker
  import pipe_tap_pkg::*;
#(
  parameter int W        = 4,
  parameter int LOCK_CNT = 4,
  parameter int ERR_MAX  = 255,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  pipe_tap_checker_if.slave bus
);

  localparam logic [CNT_W-1:0]      ERR_LIMIT  = CNT_W'(ERR_MAX);
  localparam logic [CNT_W-1:0]      CNT_SAT    = '1;
  localparam logic [VOTE_CNT_W-1:0] LOCK_LIMIT = VOTE_CNT_W'(LOCK_CNT);

  state_t                state_q, state_d;
  logic [W-1:0]          prev_b_q, prev_b_d;
  logic [W-1:0]          prev_c_q, prev_c_d;
  logic [1:0]            prime_cnt_q, prime_cnt_d;
  logic [VOTE_CNT_W-1:0] vote_cnt_q, vote_cnt_d;
  vote_t                 cand_q, cand_d;
  logic                  mode_q, mode_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;

  logic  p_ok;
  logic  k_ok;
  vote_t vote;
  logic  violate;

  pipe_tap_vote #(.W(W)) u_vote (
    .b      (bus.b),
    .c      (bus.c),
    .d      (bus.d),
    .prev_b (prev_b_q),
    .prev_c (prev_c_q),
    .p_ok   (p_ok),
    .k_ok   (k_ok),
    .vote   (vote)
  );

  // Constant data satisfies both models, so it never counts as a violation.
  assign violate = (mode_q == MODE_PIPE) ? !p_ok : !k_ok;

  always_comb begin
    state_d     = state_q;
    prev_b_d    = prev_b_q;
    prev_c_d    = prev_c_q;
    prime_cnt_d = prime_cnt_q;
    vote_cnt_d  = vote_cnt_q;
    cand_d      = cand_q;
    mode_d      = mode_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (bus.clr) begin
      state_d     = IDLE;
      prev_b_d    = '0;
      prev_c_d    = '0;
      prime_cnt_d = '0;
      vote_cnt_d  = '0;
      cand_d      = NONE;
      mode_d      = MODE_PIPE;
      err_cnt_d   = '0;
    end else if (bus.en) begin
      if (state_q != FAULT) begin
        prev_b_d = bus.b;
        prev_c_d = bus.c;
      end

      unique case (state_q)
        IDLE: begin
          prime_cnt_d = 2'd1;
          state_d     = PRIME;
        end

        PRIME: begin
          prime_cnt_d = prime_cnt_q + 2'd1;
          if (prime_cnt_q + 2'd1 >= PRIME_SAMPLES) state_d = HUNT;
        end

        HUNT: begin
          unique case (vote)
            PIPE, COLL: begin
              if (vote == cand_q) begin
                vote_cnt_d = vote_cnt_q + 1'b1;
              end else begin
                cand_d     = vote;
                vote_cnt_d = VOTE_CNT_W'(1);
              end
            end
            BAD:     vote_cnt_d = '0;
            default: ;
          endcase
          if (vote_is_real(vote) && (vote_cnt_d == LOCK_LIMIT)) begin
            state_d = LOCKED;
            mode_d  = vote_to_mode(vote);
          end
        end

        LOCKED: begin
          if (err_cnt_q >= ERR_LIMIT) begin
            state_d = FAULT;
          end else if (violate) begin
            err_d = 1'b1;
            if (err_cnt_q != CNT_SAT) err_cnt_d = err_cnt_q + 1'b1;
          end
        end

        FAULT:   ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_b_q    <= '0;
      prev_c_q    <= '0;
      prime_cnt_q <= '0;
      vote_cnt_q  <= '0;
      cand_q      <= NONE;
      mode_q      <= MODE_PIPE;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_b_q    <= prev_b_d;
      prev_c_q    <= prev_c_d;
      prime_cnt_q <= prime_cnt_d;
      vote_cnt_q  <= vote_cnt_d;
      cand_q      <= cand_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.locked       = (state_q == LOCKED) || (state_q == FAULT);
  assign bus.mode         = mode_q;
  assign bus.err          = err_q;
  assign bus.err_cnt      = err_cnt_q;
  assign bus.fault        = (state_q == FAULT);
  assign bus.state_dbg    = state_q;
  assign bus.vote_cnt_dbg = vote_cnt_q;

`ifdef PIPE_TAP_CHECKER_LOG_EN
  // Stamp is the zero-based index of the enabled sample, counted from reset or clr.
  logic [15:0]    stamp_q;
  logic [3*W-1:0] first_bad_q;
  logic [15:0]    first_stamp_q;
  logic           log_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stamp_q       <= '0;
      first_bad_q   <= '0;
      first_stamp_q <= '0;
      log_valid_q   <= 1'b0;
    end else if (bus.clr) begin
      stamp_q       <= '0;
      first_bad_q   <= '0;
      first_stamp_q <= '0;
      log_valid_q   <= 1'b0;
    end else if (bus.en) begin
      stamp_q <= stamp_q + 16'd1;
      if (err_d && !log_valid_q) begin
        first_bad_q   <= {bus.b, bus.c, bus.d};
        first_stamp_q <= stamp_q;
        log_valid_q   <= 1'b1;
      end
    end
  end

  assign bus.first_bad   = first_bad_q;
  assign bus.first_stamp = first_stamp_q;
  assign bus.log_valid   = log_valid_q;
`endif

endmodule

// File: doc/pipe_tap_checker.md
Name: pipe_tap_checker

Overview:
- Consumer end of the a->b->c->d tap chain produced by the team's assignment-ordering demo block.
- Samples the three taps every clock and classifies the chain's behaviour:
  - true 3-stage pipeline (non-blocking style), or
  - collapsed chain where all taps are equal (blocking style).
- Once a mode is locked, flags every sample that breaks it.
- Sits beside the demo block in benches and on-board demos, giving a self-checking verdict in place of manual waveform reading.

Parameters:
- W, 4, tap width in bits.
- LOCK_CNT, 4, consecutive agreeing votes required to lock a mode (must be 1..15).
- ERR_MAX, 255, err_cnt value that forces the FAULT state (must be ≤ 2^CNT_W-1).
- CNT_W, 8, width of err_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample enable; when low, all state and history hold.
- clr  in  1  synchronous clear; returns to IDLE and zeroes counters.
- b  in  W  tap 1.
- c  in  W  tap 2.
- d  in  W  tap 3.
- locked  out  1  mode is locked (LOCKED or FAULT state).
- mode  out  1  0 = pipeline, 1 = collapsed; valid only while locked.
- err  out  1  one-cycle pulse on a mismatch in LOCKED.
- err_cnt  out  CNT_W  saturating mismatch count.
- fault  out  1  high in FAULT state.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE.
  - prev_b, prev_c, vote_cnt, err_cnt = 0.
  - All outputs = 0.
- Per enabled cycle, using history registers prev_b and prev_c (the b and c values from the previous enabled sample):
  - P (pipe-consistent) = (c == prev_b) && (d == prev_c).
  - K (collapse-consistent) = (b == c) && (c == d).
  - Vote:
    - P && !K → pipeline.
    - K && !P → collapsed.
    - P && K → none (constant data).
    - !P && !K → mismatch.
- History update: prev_b <= b and prev_c <= c on every enabled cycle in every state except FAULT.
- States:
  - IDLE:
    - Enabled cycle → PRIME.
    - Load history; prime_cnt = 1.
  - PRIME:
    - Stay until 2 enabled samples have been taken so the history is valid, then → HUNT.
    - No votes or errors are generated.
  - HUNT:
    - Vote that matches the candidate → vote_cnt++.
    - Differing real vote → candidate = that vote, vote_cnt = 1.
    - None → hold.
    - Mismatch → vote_cnt = 0.
    - When vote_cnt reaches LOCK_CNT → LOCKED, with mode = candidate (registered, visible next cycle).
  - LOCKED:
    - Sample violates the locked mode (mode 0 needs P; mode 1 needs K) → err pulses 1 cycle and err_cnt++ (saturating).
    - When err_cnt reaches ERR_MAX → FAULT on the next edge.
  - FAULT:
    - Sticky; fault = 1, locked = 1; history frozen; err stays 0.
    - Only clr or reset exits.
- clr:
  - Synchronous; has priority over en and over all state logic.
  - Next state = IDLE; all counters zero; outputs zero next cycle.
- en low:
  - Nothing advances; err = 0.
  - A pending err from the prior cycle still deasserts.
- Latency: err and the locked transition are registered, appearing one clock after the offending or locking sample edge.
- Saturation: err_cnt never wraps; at 2^CNT_W-1 it holds.
- Reset mid-operation: immediate return to the reset values, including during FAULT.

Optional Feature:
- Macro: PIPE_TAP_CHECKER_LOG_EN.
- When defined:
  - Adds output first_bad (3*W bits, concatenation {b,c,d}) and first_stamp (16 bits).
  - Captures the taps and a free-running enabled-cycle counter value at the first LOCKED mismatch after reset or clr.
  - Holds them until reset or clr.
  - Adds output log_valid (1 bit).
- When not defined: the ports and logic are absent.

Decomposition:
- Shared package pipe_tap_pkg holds:
  - state encoding constants: IDLE=0, PRIME=1, HUNT=2, LOCKED=3, FAULT=4, 3 bits;
  - vote encoding constants: NONE, PIPE, COLL, BAD, 2 bits;
  - MODE_PIPE and MODE_COLL.
- One natural sub-module, pipe_tap_vote: purely combinational classification of b/c/d against the history into a vote. The FSM and counters stay in the top module.

Test Plan:
- Pipeline input: taps behave as a 3-stage shift of a = 1,2,3,4,5,6… → locked = 1 after 2 PRIME + 4 HUNT samples; mode = 0; err_cnt = 0.
- Collapsed input: b = c = d = 1,2,3,4,5,… → locked with mode = 1; a later sample b=6, c=6, d=5 → err pulse, err_cnt = 1.
- Constant input: b = c = d = 7 for 20 cycles → stays in HUNT, locked = 0; then pipeline data locks mode 0.
- Fault: with ERR_MAX = 3, inject 3 mismatches after lock → fault = 1; further mismatches leave err_cnt = 3; clr → all outputs 0, state IDLE.
- en gating and reset: deassert en for 5 cycles mid-HUNT → vote_cnt unchanged. Pulse rst_n low asynchronously between clock edges while LOCKED → outputs 0 immediately.
- With PIPE_TAP_CHECKER_LOG_EN: first mismatch at enabled cycle 12 with b=3, c=9, d=1 → first_bad = 0x391, first_stamp = 12, log_valid = 1; a second mismatch leaves the log unchanged.
